// File: rtl/mem_arb_pkg.sv
// Shared types for the icache/dcache memory arbiter: FSM states, owner tags, request register layout.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        GAP  = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam int TIMEOUT_CYCLES_DEF = 40;
    localparam int TMR_W              = 6;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter granting one icache/dcache block transaction at a time to memory.
// Latency: grant one edge after the IDLE sample; response forwarded combinationally; one GAP cycle after.
// Backpressure: requesters hold level requests until their pulse; memory stalls bounded by TIMEOUT_CYCLES.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [127:0] i_read_data,
    output logic         i_read_valid,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [127:0] d_write_data,
    output logic [127:0] d_read_data,
    output logic         d_read_valid,
    output logic         d_write_done,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_read_address,
    output logic [31:0]  mem_write_address,
    output logic [127:0] mem_write_data,
    input  logic [127:0] mem_read_data,
    input  logic         mem_read_valid,
    input  logic         mem_write_done,
    output logic         timeout_error
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    // Returns the state to enter from IDLE; IDLE itself means nobody is asking.
    function automatic arb_state_t arbitrate(input logic   i_req,
                                             input logic   d_rd,
                                             input logic   d_wr,
                                             input owner_t last);
        arb_state_t d_st;
        arb_state_t res;
        d_st = d_wr ? D_WR : D_RD;
        res  = IDLE;
        if (i_req && (d_rd || d_wr))
            res = (last == OWNER_I) ? d_st : I_RD;
        else if (i_req)
            res = I_RD;
        else if (d_rd || d_wr)
            res = d_st;
        return res;
    endfunction

    arb_state_t       state_q, state_d, grant_st;
    owner_t           last_owner_q;
    logic [TMR_W-1:0] tmr_q;
    mem_req_t         req_q;
    logic             busy, resp, timeout_hit;

    always_comb begin
        grant_st    = arbitrate(i_read, d_read, d_write, last_owner_q);
        busy        = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
        resp        = ((state_q == I_RD) && mem_read_valid) ||
                      ((state_q == D_RD) && mem_read_valid) ||
                      ((state_q == D_WR) && mem_write_done);
        timeout_hit = busy && !resp && (tmr_q == TMR_LAST);
        state_d     = state_q;
        case (state_q)
            IDLE:             state_d = grant_st;
            I_RD, D_RD, D_WR: if (resp || timeout_hit) state_d = GAP;
            GAP:              state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_I;
            tmr_q        <= '0;
            req_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_st != IDLE) begin
                tmr_q        <= '0;
                last_owner_q <= (grant_st == I_RD) ? OWNER_I : OWNER_D;
                req_q.addr   <= (grant_st == I_RD) ? i_address : d_address;
                if (grant_st == D_WR)
                    req_q.data <= d_write_data;
            end else if (busy) begin
                tmr_q <= tmr_q + 1'b1;
            end else begin
                tmr_q <= '0;
            end
        end
    end

    assign mem_read          = (state_q == I_RD) || (state_q == D_RD);
    assign mem_write         = (state_q == D_WR);
    assign mem_read_address  = req_q.addr;
    assign mem_write_address = req_q.addr;
    assign mem_write_data    = req_q.data;

    // Pulses are masked while reset is asserted so an aborted transaction never completes.
    assign i_read_valid  = reset_n && (state_q == I_RD) && mem_read_valid;
    assign d_read_valid  = reset_n && (state_q == D_RD) && mem_read_valid;
    assign d_write_done  = reset_n && (state_q == D_WR) && mem_write_done;
    assign timeout_error = reset_n && timeout_hit;
    assign i_read_data   = mem_read_data;
    assign d_read_data   = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bench drives memory responses by hand and checks every pulse and strobe.
module tb_mem_arbiter;

    logic         clock;
    logic         reset_n;
    logic         i_read;
    logic [31:0]  i_address;
    logic [127:0] i_read_data;
    logic         i_read_valid;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [127:0] d_write_data;
    logic [127:0] d_read_data;
    logic         d_read_valid;
    logic         d_write_done;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_read_address;
    logic [31:0]  mem_write_address;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data;
    logic         mem_read_valid;
    logic         mem_write_done;
    logic         timeout_error;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(40)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .i_read            (i_read),
        .i_address         (i_address),
        .i_read_data       (i_read_data),
        .i_read_valid      (i_read_valid),
        .d_read            (d_read),
        .d_write           (d_write),
        .d_address         (d_address),
        .d_write_data      (d_write_data),
        .d_read_data       (d_read_data),
        .d_read_valid      (d_read_valid),
        .d_write_done      (d_write_done),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data),
        .mem_read_valid    (mem_read_valid),
        .mem_write_done    (mem_write_done),
        .timeout_error     (timeout_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        i_read         = 1'b0;
        d_read         = 1'b0;
        d_write        = 1'b0;
        mem_read_valid = 1'b0;
        mem_write_done = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [127:0] pat_aa;
    logic [127:0] stored;
    logic [31:0]  exp_addr;
    logic         exp_d;
    logic         saw_v;
    logic         strobe_ok;
    int           cyc;
    int           lowcnt;

    initial begin
        i_address     = '0;
        d_address     = '0;
        d_write_data  = '0;
        mem_read_data = '0;
        pat_aa        = {16{8'hAA}};
        apply_reset();
        reset_n = 1'b0;
        step();

        // reset state
        check("rst_mem_read",  128'(mem_read), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_timeout",   128'(timeout_error), 128'd0);
        check("rst_rd_addr",   128'(mem_read_address), 128'd0);
        check("rst_wr_data",   mem_write_data, 128'd0);
        reset_n = 1'b1;
        step();

        // single icache read, response after 11 cycles
        i_read    = 1'b1;
        i_address = 32'h40;
        step();
        check("i1_mem_read", 128'(mem_read), 128'd1);
        check("i1_addr",     128'(mem_read_address), 128'h40);
        check("i1_no_write", 128'(mem_write), 128'd0);
        strobe_ok = 1'b1;
        repeat (10) begin
            step();
            if (!mem_read || i_read_valid) strobe_ok = 1'b0;
        end
        check("i1_strobe_held", 128'(strobe_ok), 128'd1);
        mem_read_valid = 1'b1;
        mem_read_data  = pat_aa;
        #1;
        check("i1_valid",   128'(i_read_valid), 128'd1);
        check("i1_data",    i_read_data, pat_aa);
        check("i1_d_quiet", 128'(d_read_valid), 128'd0);
        step();
        i_read = 1'b0;
        #1;
        check("i1_gap_strobe", 128'(mem_read), 128'd0);
        check("i1_gap_drop",   128'(i_read_valid), 128'd0);
        mem_read_valid = 1'b0;
        step();
        check("i1_idle_strobe", 128'(mem_read), 128'd0);

        // simultaneous reads from reset: dcache first, then icache
        apply_reset();
        i_read    = 1'b1;
        d_read    = 1'b1;
        i_address = 32'h100;
        d_address = 32'h200;
        step();
        check("tie_d_addr", 128'(mem_read_address), 128'h200);
        mem_read_valid = 1'b1;
        mem_read_data  = 128'h5151;
        #1;
        check("tie_d_valid", 128'(d_read_valid), 128'd1);
        check("tie_i_quiet", 128'(i_read_valid), 128'd0);
        check("tie_d_data",  d_read_data, 128'h5151);
        step();
        mem_read_valid = 1'b0;
        d_read         = 1'b0;
        lowcnt = 0;
        while (!mem_read && lowcnt < 10) begin
            lowcnt++;
            step();
        end
        check("tie_low_cycles", 128'(lowcnt), 128'd2);
        check("tie_i_addr",     128'(mem_read_address), 128'h100);
        mem_read_valid = 1'b1;
        #1;
        check("tie_i_valid", 128'(i_read_valid), 128'd1);
        step();
        mem_read_valid = 1'b0;
        i_read         = 1'b0;
        step();
        step();

        // write wins over read inside dcache; read returns the written block
        d_write      = 1'b1;
        d_read       = 1'b1;
        d_address    = 32'h80;
        d_write_data = 128'h1234;
        step();
        check("wr_strobe",  128'(mem_write), 128'd1);
        check("wr_no_read", 128'(mem_read), 128'd0);
        check("wr_addr",    128'(mem_write_address), 128'h80);
        check("wr_data",    mem_write_data, 128'h1234);
        stored = mem_write_data;
        step();
        step();
        mem_write_done = 1'b1;
        #1;
        check("wr_done", 128'(d_write_done), 128'd1);
        step();
        mem_write_done = 1'b0;
        d_write        = 1'b0;
        step();
        step();
        check("rd_after_wr_strobe", 128'(mem_read), 128'd1);
        check("rd_after_wr_addr",   128'(mem_read_address), 128'h80);
        mem_read_valid = 1'b1;
        mem_read_data  = stored;
        #1;
        check("rd_after_wr_valid", 128'(d_read_valid), 128'd1);
        check("rd_after_wr_data",  d_read_data, 128'h1234);
        step();
        mem_read_valid = 1'b0;
        d_read         = 1'b0;
        step();
        step();

        // timeout with no memory response, then re-grant
        i_read    = 1'b1;
        i_address = 32'h300;
        step();
        cyc   = 1;
        saw_v = 1'b0;
        while (!timeout_error && cyc < 60) begin
            if (i_read_valid) saw_v = 1'b1;
            step();
            cyc++;
        end
        check("to_cycle",    128'(cyc), 128'd40);
        check("to_pulse",    128'(timeout_error), 128'd1);
        check("to_no_valid", 128'(saw_v | i_read_valid), 128'd0);
        step();
        check("to_gap_pulse",  128'(timeout_error), 128'd0);
        check("to_gap_strobe", 128'(mem_read), 128'd0);
        step();
        step();
        check("to_regrant",      128'(mem_read), 128'd1);
        check("to_regrant_addr", 128'(mem_read_address), 128'h300);
        mem_read_valid = 1'b1;
        #1;
        check("to_regrant_valid", 128'(i_read_valid), 128'd1);
        step();
        mem_read_valid = 1'b0;
        i_read         = 1'b0;
        step();
        step();

        // reset in the middle of a dcache read
        d_read    = 1'b1;
        d_address = 32'h500;
        step();
        repeat (4) step();
        check("mid_rst_busy", 128'(mem_read), 128'd1);
        reset_n = 1'b0;
        d_read  = 1'b0;
        step();
        check("mid_rst_drop", 128'(mem_read), 128'd0);
        reset_n = 1'b1;
        repeat (5) step();
        mem_read_valid = 1'b1;
        #1;
        check("mid_rst_late_d", 128'(d_read_valid), 128'd0);
        check("mid_rst_late_i", 128'(i_read_valid), 128'd0);
        step();
        mem_read_valid = 1'b0;
        #1;
        check("mid_rst_idle", 128'({mem_read, mem_write}), 128'd0);

        // sustained requests alternate D, I, D, I; address changes mid-flight are ignored
        i_read    = 1'b1;
        d_read    = 1'b1;
        i_address = 32'h600;
        d_address = 32'h700;
        step();
        for (int t = 0; t < 4; t++) begin
            exp_d    = (t % 2 == 0);
            exp_addr = exp_d ? d_address : i_address;
            check("rr_addr", 128'(mem_read_address), 128'(exp_addr));
            step();
            i_address = i_address + 32'h10;
            #1;
            check("rr_addr_hold", 128'(mem_read_address), 128'(exp_addr));
            mem_read_valid = 1'b1;
            mem_read_data  = 128'(t + 1);
            #1;
            check("rr_i_valid", 128'(i_read_valid), 128'(!exp_d));
            check("rr_d_valid", 128'(d_read_valid), 128'(exp_d));
            step();
            mem_read_valid = 1'b0;
            step();
            step();
        end
        i_read         = 1'b0;
        d_read         = 1'b0;
        mem_read_valid = 1'b1;
        #1;
        check("rr_fifth_d", 128'(d_read_valid), 128'd1);
        step();
        mem_read_valid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
